// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Definitions shared by the LCD SPI byte writer and the drawing front ends
// that feed it. These are the transfer state encoding, the D/C polarity and
// the ILI9486 window and RAM-write command codes.
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package lcd_pkg;

    // Byte writer transfer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_DONE     = 3'd4,
        ST_GAP      = 3'd5
    } lcd_state_t;

    // D/C line polarity on the panel
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // ILI9486 commands used by the window and picture sequencers
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/lcd_spi_clk_div.sv
// -----------------------------------------------------------------------------
// lcd_spi_clk_div
// This is a loadable phase counter that times each SCLK half-period. A load
// starts a new phase. phase_end is high during the last clk cycle of that
// phase, which lasts CLK_DIV cycles.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   start a new phase in the next cycle
//   phase_end  out  current phase ends at the coming clk edge
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lcd_spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic phase_end
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    // A load places CLK_DIV-1 in the counter. The counter then counts down
    // and stops at zero, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= RELOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign phase_end = (cnt_reg == '0);

endmodule

// File: rtl/lcd_spi_byte_writer.sv
// -----------------------------------------------------------------------------
// lcd_spi_byte_writer
// This is the SPI mode-0 back end for the ILI9486 panel. Each request sends
// one byte, MSB first, and drives D/C alongside it. The block answers each
// byte with a single-cycle lcd_wr_done pulse.
//
// Optional build macro: LCD_SPI_CS_BURST_EN
//   When this macro is defined, chip select stays low after a byte. A new
//   request that arrives during the CS gap goes straight into SETUP. CS is
//   raised only when the gap expires with no request. When the macro is
//   undefined, CS goes high after every byte.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (>=1)
//   CS_GAP   minimum clk cycles with lcd_cs_n high between bytes (>=1)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   lcd_wr_en    in   byte request, held by the front end until done
//   lcd_data     in   byte to send
//   add_dc       in   0 = command, 1 = data
//   lcd_wr_done  out  one-cycle pulse once the byte has left the pins
//   lcd_busy     out  high from accept until the end of the CS gap
//   lcd_sclk     out  SPI clock, idle low
//   lcd_mosi     out  SPI data
//   lcd_cs_n     out  chip select, active low
//   lcd_dc       out  registered D/C
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lcd_spi_byte_writer
    import lcd_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_wr_en,
    input  logic [7:0] lcd_data,
    input  logic       add_dc,
    output logic       lcd_wr_done,
    output logic       lcd_busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_cs_n,
    output logic       lcd_dc
);

    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(CS_GAP - 1);

    lcd_state_t    state_reg;
    logic [7:0]    shift_reg;
    logic          dc_hold_reg;
    logic [2:0]    bit_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          armed_reg;
    logic          first_reg;      // first SETUP cycle: drive the pins, start the divider
    logic          div_load;
    logic          phase_end;
    logic          accept;

    lcd_spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .phase_end (phase_end)
    );

    // A held request is accepted only once. armed must see wr_en low again
    // before the next byte can be accepted.
`ifdef LCD_SPI_CS_BURST_EN
    assign accept = lcd_wr_en && armed_reg &&
                    ((state_reg == ST_IDLE) || (state_reg == ST_GAP));
`else
    assign accept = lcd_wr_en && armed_reg && (state_reg == ST_IDLE);
`endif

    // The divider restarts in the first SETUP cycle and at every phase end.
    // The divider starts in the first SETUP cycle, and any stale phase_end
    // from the previous byte is ignored there.
    always_comb begin
        div_load = 1'b0;
        if (state_reg == ST_SETUP && first_reg) begin
            div_load = 1'b1;
        end else if ((state_reg == ST_SETUP || state_reg == ST_SHIFT_HI ||
                      state_reg == ST_SHIFT_LO) && phase_end) begin
            div_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            dc_hold_reg <= 1'b0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            armed_reg   <= 1'b1;
            first_reg   <= 1'b0;
            lcd_wr_done <= 1'b0;
            lcd_busy    <= 1'b0;
            lcd_sclk    <= 1'b0;
            lcd_mosi    <= 1'b0;
            lcd_cs_n    <= 1'b1;
            lcd_dc      <= 1'b0;
        end else begin
            lcd_wr_done <= 1'b0;
            if (!lcd_wr_en) begin
                armed_reg <= 1'b1;
            end

            if (accept) begin
                shift_reg   <= lcd_data;
                dc_hold_reg <= add_dc;
                armed_reg   <= 1'b0;
                lcd_busy    <= 1'b1;
                bit_cnt_reg <= 3'd7;
                first_reg   <= 1'b1;
                state_reg   <= ST_SETUP;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // wait for an armed request
                    end

                    ST_SETUP: begin
                        if (first_reg) begin
                            first_reg <= 1'b0;
                            lcd_cs_n  <= 1'b0;
                            lcd_dc    <= dc_hold_reg;
                            lcd_mosi  <= shift_reg[7];
                        end else if (phase_end) begin
                            lcd_sclk  <= 1'b1;
                            state_reg <= ST_SHIFT_HI;
                        end
                    end

                    ST_SHIFT_HI: begin
                        if (phase_end) begin
                            lcd_sclk  <= 1'b0;
                            state_reg <= ST_SHIFT_LO;
                            // Advance MOSI on the falling edge. After the
                            // last bit there is no next bit, so keep bit 0.
                            if (bit_cnt_reg != 3'd0) begin
                                lcd_mosi  <= shift_reg[6];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                            end
                        end
                    end

                    ST_SHIFT_LO: begin
                        if (phase_end) begin
                            if (bit_cnt_reg == 3'd0) begin
                                lcd_wr_done <= 1'b1;
                                lcd_mosi    <= 1'b0;
`ifndef LCD_SPI_CS_BURST_EN
                                lcd_cs_n    <= 1'b1;
`endif
                                state_reg   <= ST_DONE;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - 1'b1;
                                lcd_sclk    <= 1'b1;
                                state_reg   <= ST_SHIFT_HI;
                            end
                        end
                    end

                    ST_DONE: begin
                        gap_cnt_reg <= GAP_RELOAD;
                        state_reg   <= ST_GAP;
                    end

                    ST_GAP: begin
                        if (gap_cnt_reg == '0) begin
                            lcd_busy  <= 1'b0;
                            lcd_cs_n  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
